// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin arbiter sharing one combinational alu among NREQ requesters
// Grants one request per IDLE visit, runs it through the alu and holds the result until accepted.
module alu_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [16*NREQ-1:0] req_a,
    input  logic [16*NREQ-1:0] req_b,
    input  logic [4*NREQ-1:0] req_op,
    input  logic [NREQ-1:0]   req_cin,
    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_cin,
    input  logic [15:0]       alu_c,
    input  logic [4:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_c,
    output logic [4:0]        rsp_flags,
    output logic [15:0]       op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [15:0]    alu_a_q, alu_a_d;
    logic [15:0]    alu_b_q, alu_b_d;
    logic [3:0]     alu_op_q, alu_op_d;
    logic           alu_cin_q, alu_cin_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [15:0]    rsp_c_q, rsp_c_d;
    logic [4:0]     rsp_flags_q, rsp_flags_d;
    logic [15:0]    op_count_q, op_count_d;

    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] ptr_next;
    logic [NREQ-1:0] grant;

    // Search upward from ptr, wrapping at NREQ; the first valid requester wins.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
        ptr_next = IDW'((int'(winner) + 1) % NREQ);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_cin_d   = alu_cin_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_c_d     = rsp_c_q;
        rsp_flags_d = rsp_flags_q;
        op_count_d  = op_count_q;
        grant       = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant     = NREQ'(1) << winner;
                    alu_a_d   = req_a[16*winner +: 16];
                    alu_b_d   = req_b[16*winner +: 16];
                    alu_op_d  = req_op[4*winner +: 4];
                    alu_cin_d = req_cin[winner];
                    id_d      = winner;
                    ptr_d     = ptr_next;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_c_d     = alu_c;
                rsp_flags_d = alu_flags;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d  = op_count_q + 16'd1;
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_c_q     <= '0;
            rsp_flags_q <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_cin_q   <= alu_cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_c_q     <= rsp_c_d;
            rsp_flags_q <= rsp_flags_d;
            op_count_q  <= op_count_d;
        end
    end

    // Grant is combinational, so it is masked while reset is held to keep every output at 0.
    assign req_ready = rst ? '0 : grant;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_cin   = alu_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_flags = rsp_flags_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - directed self-checking bench for alu_rr_arbiter
// A tiny alu model (op 0: a+b+cin, else a^b; Z flag only) closes the loop.
module tb_alu_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [7:0]  req_op = '0;
    logic [1:0]  req_cin = '0;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [3:0]  alu_op;
    logic        alu_cin;
    logic [4:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [0:0]  rsp_id;
    logic [15:0] rsp_c;
    logic [4:0]  rsp_flags;
    logic [15:0] op_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_cnt  = '0;

    always #5 clk = ~clk;

    assign alu_c     = (alu_op == 4'd0) ? (alu_a + alu_b + {15'b0, alu_cin}) : (alu_a ^ alu_b);
    assign alu_flags = {(alu_c == 16'h0000), 4'b0000};

    alu_rr_arbiter #(.NREQ(2), .IDW(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_c(rsp_c), .rsp_flags(rsp_flags), .op_count(op_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        n_checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== 4'h0 || alu_cin !== 1'b0) begin n_fail++; $display("FAIL reset_alu got %h %h %h %b want 0", alu_a, alu_b, alu_op, alu_cin); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_c !== 16'h0 || rsp_flags !== 5'h0 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got %b %h %h %b want 0", rsp_valid, rsp_c, rsp_flags, rsp_id); end
        n_checks++; if (op_count !== 16'h0) begin n_fail++; $display("FAIL reset_op_count got %h want 0000", op_count); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        req_a = {16'h0000, 16'h0001};
        req_b = {16'h0000, 16'h0002};
        req_op = 8'h00;
        req_cin = 2'b00;
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant got %b want 01", req_ready); end
        step();
        req_valid = 2'b00;
        n_checks++; if (alu_a !== 16'h0001 || alu_b !== 16'h0002) begin n_fail++; $display("FAIL single_alu_ops got %h %h want 0001 0002", alu_a, alu_b); end
        n_checks++; if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_exec got ready %b valid %b want 00 0", req_ready, rsp_valid); end
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_c !== 16'h0003) begin n_fail++; $display("FAIL single_rsp got %b %b %h want 1 0 0003", rsp_valid, rsp_id, rsp_c); end
        n_checks++; if (rsp_flags !== 5'h00) begin n_fail++; $display("FAIL single_flags got %h want 00", rsp_flags); end
        step();
        exp_cnt++;
        n_checks++; if (op_count !== 16'h0001 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_done got cnt %h valid %b want 0001 0", op_count, rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_c;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = '0;
        req_a = {16'h1234, 16'h0010};
        req_b = {16'h1111, 16'h0020};
        req_op = 8'h10;
        req_cin = 2'b00;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_c = (k % 2 == 0) ? 16'h0030 : 16'h0325;
            #1;
            n_checks++; if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rr_grant_%0d got %b", k, req_ready); end
            step();
            step();
            n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(k % 2) || rsp_c !== exp_c) begin n_fail++; $display("FAIL rr_rsp_%0d got %b %b %h want 1 %0d %h", k, rsp_valid, rsp_id, rsp_c, k % 2, exp_c); end
            step();
            exp_cnt++;
        end
        n_checks++; if (op_count !== 16'd4) begin n_fail++; $display("FAIL rr_op_count got %0d want 4", op_count); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_grant got %b want 01", req_ready); end
        step();
        step();
        for (int k = 0; k < 10; k++) begin
            n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_c !== 16'h0030 || req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_hold_%0d got %b %b %h %b", k, rsp_valid, rsp_id, rsp_c, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        step();
        exp_cnt++;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_next_grant got %b want 10", req_ready); end
        n_checks++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL bp_op_count got %0d want %0d", op_count, exp_cnt); end
        step();
        step();
        step();
        exp_cnt++;
        req_valid = 2'b00;
    endtask

    task automatic test_drop();
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL drop_first_grant got %b want 01", req_ready); end
        step();
        req_valid = 2'b10;
        step();
        req_valid = 2'b01;
        step();
        exp_cnt++;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL drop_req0_wins got %b want 01", req_ready); end
        step();
        req_valid = 2'b11;
        step();
        step();
        exp_cnt++;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL drop_ptr_is_1 got %b want 10", req_ready); end
        step();
        req_valid = 2'b00;
        step();
        step();
        exp_cnt++;
        n_checks++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL drop_op_count got %0d want %0d", op_count, exp_cnt); end
    endtask

    task automatic test_reset_mid_resp();
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        step();
        step();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_in_resp got %b want 1", rsp_valid); end
        rst = 1'b1;
        #1;
        n_checks++; if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_c !== 16'h0 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp got %b %b %h %b want 0", req_ready, rsp_valid, rsp_c, rsp_id); end
        n_checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || op_count !== 16'h0) begin n_fail++; $display("FAIL midrst_regs got %h %h %h want 0", alu_a, alu_b, op_count); end
        step();
        rst = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();
        step();
        step();
        n_checks++; if (rsp_valid !== 1'b0 || op_count !== 16'h0) begin n_fail++; $display("FAIL midrst_after got %b %h want 0 0000", rsp_valid, op_count); end
    endtask

    task automatic test_wrap();
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        step();
        n_checks++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffff", op_count); end
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        step();
        req_valid = 2'b00;
        step();
        n_checks++; if (op_count !== 16'hFFFF || rsp_c !== 16'h0030) begin n_fail++; $display("FAIL wrap_resp got %h %h want ffff 0030", op_count, rsp_c); end
        step();
        n_checks++; if (op_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_rollover got %h want 0000", op_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drop();
        test_reset_mid_resp();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
